// File: rtl/soc_rst_sequencer.sv
// rtl/soc_rst_sequencer.sv - PLL/SoC reset sequencer with lock qualification and debounced button
module soc_rst_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 1000000,
    parameter int DEBOUNCE_CYCLES     = 65536,
    parameter int CNT_W               = 20
) (
    input  logic       io_axiClk,
    input  logic       io_asyncReset,
    input  logic       io_locked,
    input  logic       io_extReset,
    output logic       io_pllReset,
    output logic       io_socResetn,
    output logic [2:0] io_state,
    output logic [3:0] io_retryCnt
);

    localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DB_LAST      = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        HOLD      = 3'd4
    } state_t;

    logic             lock_m, lock_s;
    logic             ext_m, ext_s;
    logic             db;
    logic [CNT_W-1:0] db_cnt;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [3:0]       retry, retry_next;

    logic             pll_q, socn_q;
    logic [2:0]       state_q;

    // Two-flop synchronizers for the asynchronous lock and button inputs
    always_ff @(posedge io_axiClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
            ext_m  <= 1'b0;
            ext_s  <= 1'b0;
        end else begin
            lock_m <= io_locked;
            lock_s <= lock_m;
            ext_m  <= io_extReset;
            ext_s  <= ext_m;
        end
    end

    // Button debounce: a new level must persist DEBOUNCE_CYCLES edges before db follows
    always_ff @(posedge io_axiClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            db     <= 1'b0;
            db_cnt <= '0;
        end else if (ext_s == db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db     <= ~db;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + CNT_W'(1);
        end
    end

    // Next-state, shared cycle counter and retry counter; lock loss outranks the button
    always_comb begin
        next_state = state;
        cnt_next   = cnt + CNT_W'(1);
        retry_next = retry;
        case (state)
            PLL_RST: begin
                if (cnt == PLL_LAST) next_state = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    next_state = STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    next_state = PLL_RST;
                    if (retry != 4'hF) retry_next = retry + 4'd1;
                end
            end
            STABLE: begin
                if (!lock_s) next_state = WAIT_LOCK;
                else if (cnt == STABLE_LAST) next_state = RUN;
            end
            RUN: begin
                cnt_next = cnt;
                if (!lock_s) next_state = WAIT_LOCK;
                else if (db) next_state = HOLD;
            end
            HOLD: begin
                cnt_next = cnt;
                if (!lock_s) next_state = WAIT_LOCK;
                else if (!db) next_state = STABLE;
            end
            default: begin
                next_state = PLL_RST;
            end
        endcase
        if (next_state != state) cnt_next = '0;
    end

    // State register plus registered outputs decoded from the next state so they are glitch-free
    always_ff @(posedge io_axiClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            state   <= PLL_RST;
            cnt     <= '0;
            retry   <= 4'd0;
            pll_q   <= 1'b1;
            socn_q  <= 1'b0;
            state_q <= 3'd0;
        end else begin
            state   <= next_state;
            cnt     <= cnt_next;
            retry   <= retry_next;
            pll_q   <= (next_state == PLL_RST);
            socn_q  <= (next_state == RUN);
            state_q <= next_state;
        end
    end

    assign io_pllReset  = pll_q;
    assign io_socResetn = socn_q;
    assign io_state     = state_q;
    assign io_retryCnt  = retry;

endmodule

// File: tb/tb_soc_rst_sequencer.sv
// tb/tb_soc_rst_sequencer.sv - directed table-driven bench for soc_rst_sequencer
module tb_soc_rst_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       ext = 1'b0;
    logic       pll;
    logic       socn;
    logic [2:0] st;
    logic [3:0] retry;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       locked;
        logic       ext;
        int         adv;
        logic [2:0] st;
        logic       pll;
        logic       socn;
        logic [3:0] retry;
        string      name;
    } vec_t;

    vec_t vecs[20];

    soc_rst_sequencer #(
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .DEBOUNCE_CYCLES     (4),
        .CNT_W               (20)
    ) dut (
        .io_axiClk     (clk),
        .io_asyncReset (rst),
        .io_locked     (locked),
        .io_extReset   (ext),
        .io_pllReset   (pll),
        .io_socResetn  (socn),
        .io_state      (st),
        .io_retryCnt   (retry)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [2:0] e_st, input logic e_pll,
                             input logic e_socn, input logic [3:0] e_retry);
        check({name, ".state"}, int'(st), int'(e_st));
        check({name, ".pll"}, int'(pll), int'(e_pll));
        check({name, ".socn"}, int'(socn), int'(e_socn));
        check({name, ".retry"}, int'(retry), int'(e_retry));
    endtask

    // Advance n rising edges, then settle at the following falling edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_vecs(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            locked = vecs[i].locked;
            ext    = vecs[i].ext;
            if (vecs[i].adv > 0) tick(vecs[i].adv);
            check_all(vecs[i].name, vecs[i].st, vecs[i].pll, vecs[i].socn, vecs[i].retry);
        end
    endtask

    initial begin
        // Edge numbers in names count rising edges after reset release
        vecs[0]  = '{1'b1, 1'b0, 0, 3'd0, 1'b1, 1'b0, 4'd0, "rst_rel"};
        vecs[1]  = '{1'b1, 1'b0, 3, 3'd0, 1'b1, 1'b0, 4'd0, "pll_e3"};
        vecs[2]  = '{1'b1, 1'b0, 1, 3'd1, 1'b0, 1'b0, 4'd0, "wait_e4"};
        vecs[3]  = '{1'b1, 1'b0, 1, 3'd2, 1'b0, 1'b0, 4'd0, "stable_e5"};
        vecs[4]  = '{1'b1, 1'b0, 7, 3'd2, 1'b0, 1'b0, 4'd0, "stable_e12"};
        vecs[5]  = '{1'b1, 1'b0, 1, 3'd3, 1'b0, 1'b1, 4'd0, "run_e13"};
        vecs[6]  = '{1'b1, 1'b1, 3, 3'd3, 1'b0, 1'b1, 4'd0, "pulse_e16"};
        vecs[7]  = '{1'b1, 1'b0, 3, 3'd3, 1'b0, 1'b1, 4'd0, "pulse_e19"};
        vecs[8]  = '{1'b1, 1'b1, 6, 3'd3, 1'b0, 1'b1, 4'd0, "press_e25"};
        vecs[9]  = '{1'b1, 1'b1, 1, 3'd4, 1'b0, 1'b0, 4'd0, "hold_e26"};
        vecs[10] = '{1'b1, 1'b0, 6, 3'd4, 1'b0, 1'b0, 4'd0, "release_e32"};
        vecs[11] = '{1'b1, 1'b0, 1, 3'd2, 1'b0, 1'b0, 4'd0, "stable_e33"};
        vecs[12] = '{1'b1, 1'b0, 7, 3'd2, 1'b0, 1'b0, 4'd0, "stable_e40"};
        vecs[13] = '{1'b1, 1'b0, 1, 3'd3, 1'b0, 1'b1, 4'd0, "run_e41"};
        vecs[14] = '{1'b0, 1'b0, 2, 3'd3, 1'b0, 1'b1, 4'd0, "lockloss_e43"};
        vecs[15] = '{1'b0, 1'b0, 1, 3'd1, 1'b0, 1'b0, 4'd0, "wait_e44"};
        vecs[16] = '{1'b1, 1'b0, 2, 3'd1, 1'b0, 1'b0, 4'd0, "relock_e46"};
        vecs[17] = '{1'b1, 1'b0, 1, 3'd2, 1'b0, 1'b0, 4'd0, "stable_e47"};
        vecs[18] = '{1'b1, 1'b0, 7, 3'd2, 1'b0, 1'b0, 4'd0, "stable_e54"};
        vecs[19] = '{1'b1, 1'b0, 1, 3'd3, 1'b0, 1'b1, 4'd0, "run_e55"};

        // Reset held across clock edges
        locked = 1'b1;
        repeat (2) @(negedge clk);
        check_all("in_reset", 3'd0, 1'b1, 1'b0, 4'd0);
        rst = 1'b0;

        // Bring-up, button pulse/press/release, lock loss and relock
        run_vecs(0, 19);

        // Lock drop and debounced press land on the same edge: lock loss wins
        ext = 1'b1;
        tick(4);
        locked = 1'b0;
        tick(1);
        check_all("simul_e60", 3'd3, 1'b0, 1'b1, 4'd0);
        tick(1);
        check_all("simul_e61", 3'd3, 1'b0, 1'b1, 4'd0);
        tick(1);
        check_all("simul_e62", 3'd1, 1'b0, 1'b0, 4'd0);
        ext = 1'b0;

        // Lock timeout and retry saturation
        do_reset();
        locked = 1'b0;
        tick(35);
        check_all("timeout_e35", 3'd1, 1'b0, 1'b0, 4'd0);
        tick(1);
        check_all("timeout_e36", 3'd0, 1'b1, 1'b0, 4'd1);
        tick(36);
        check_all("timeout_e72", 3'd0, 1'b1, 1'b0, 4'd2);
        tick(36 * 13);
        check_all("timeout_e540", 3'd0, 1'b1, 1'b0, 4'd15);
        tick(72);
        check_all("saturate_e612", 3'd0, 1'b1, 1'b0, 4'd15);

        // Async reset asserted between edges while in STABLE
        locked = 1'b1;
        tick(5);
        check_all("pre_areset_e617", 3'd2, 1'b0, 1'b0, 4'd15);
        #2;
        rst = 1'b1;
        #1;
        check_all("areset_now", 3'd0, 1'b1, 1'b0, 4'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_vecs(0, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/soc_rst_sequencer.md
SOC_RST_SEQUENCER -- requirements
Module: soc_rst_sequencer

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16, meaning cycles io_pllReset is held per PLL reset pulse.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024, meaning consecutive synchronized-lock cycles required before SoC release.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 1000000, meaning cycles waited for lock before PLL is re-reset.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 65536, meaning consecutive cycles a changed button level must persist.
REQ-005 SHALL have parameter CNT_W, default 20, meaning width of the shared cycle counter; all cycle parameters SHALL be at most 2^CNT_W.
REQ-006 SHALL have port io_axiClk  input  1  single clock: free-running board clock, which is not the PLL output.
REQ-007 SHALL have port io_asyncReset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port io_locked  input  1  PLL lock, asynchronous to io_axiClk.
REQ-009 SHALL have port io_extReset  input  1  push-button reset request, active-high, asynchronous, bouncy.
REQ-010 SHALL have port io_pllReset  output  1  reset to PLL, active-high.
REQ-011 SHALL have port io_socResetn  output  1  reset to SoC, active-low.
REQ-012 SHALL have port io_state  output  3  current state encoding.
REQ-013 SHALL have port io_retryCnt  output  4  count of lock timeouts, saturating.

Function
REQ-014 SHALL synchronize io_locked and io_extReset each through two flops (lock_s, ext_s) before any use.
REQ-015 SHALL debounce ext_s into db: counter clears whenever ext_s equals db; otherwise the counter increments, and when it is at DEBOUNCE_CYCLES-1 with ext_s still different, db toggles and the counter clears.
REQ-016 SHALL implement these states: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, HOLD=4. Codes 5-7 SHALL go to PLL_RST on the next edge.
REQ-017 SHALL clear the cycle counter on every state entry.
REQ-018 In PLL_RST, at each edge: go to WAIT_LOCK if cnt==PLL_RST_CYCLES-1, else increment cnt. io_pllReset is high for exactly PLL_RST_CYCLES cycles.
REQ-019 In WAIT_LOCK: lock_s=1 goes to STABLE. Otherwise, cnt==LOCK_TIMEOUT_CYCLES-1 goes to PLL_RST and increments io_retryCnt, saturating at 15. Otherwise cnt increments.
REQ-020 In STABLE: lock_s=0 goes to WAIT_LOCK. Otherwise, cnt==LOCK_STABLE_CYCLES-1 goes to RUN. Otherwise cnt increments.
REQ-021 In RUN: lock_s=0 goes to WAIT_LOCK, with priority over the button. Otherwise db=1 goes to HOLD.
REQ-022 In HOLD: lock_s=0 goes to WAIT_LOCK. Otherwise db=0 goes to STABLE, so lock is requalified before release.
REQ-023 SHALL drive io_pllReset, io_socResetn and io_state from dedicated flops updated on the same edge as the state register. io_pllReset=1 only in PLL_RST; io_socResetn=1 only in RUN. All three SHALL be glitch-free.
REQ-024 io_retryCnt SHALL clear only on io_asyncReset.

Reset
REQ-025 While io_asyncReset is high, the block SHALL immediately hold all of the following, including mid-operation:
- state=PLL_RST, counters=0, sync flops=0, db=0
- io_pllReset=1, io_socResetn=0, io_state=0, io_retryCnt=0
REQ-026 After deassertion, the first rising edge is edge 1. The sequence SHALL restart from PLL_RST.

Verification
Parameters for all scenarios: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, DEBOUNCE_CYCLES=4.
REQ-027 Nominal bring-up: io_locked=1 constant -> io_pllReset high through edge 4, WAIT_LOCK after edge 4, STABLE after edge 5, io_socResetn=1 after edge 13, io_state=3.
REQ-028 Lock timeout: io_locked=0 -> PLL_RST re-entered after edge 36 with io_retryCnt=1. Holding io_locked=0 for more than 15 retries -> io_retryCnt stays 15.
REQ-029 Lock loss in RUN: io_locked falls before edge a -> io_socResetn=0 and io_state=1 after edge a+2. Restoring lock -> RUN again 9 edges after lock_s returns.
REQ-030 Button debounce, two cases:
- 3-cycle pulse on io_extReset in RUN -> no state change.
- Sustained press -> HOLD and io_socResetn=0. Release -> STABLE, then RUN 8 edges later.
REQ-031 Async reset mid-operation: assert io_asyncReset between edges while in STABLE -> io_pllReset=1 and io_socResetn=0 without waiting for a clock edge. Deassert -> REQ-027 timing repeats.
REQ-032 Simultaneous events: in RUN, lock_s falls on the same edge db rises -> next state WAIT_LOCK, not HOLD.
